// File: rtl/traffic_ctrl.sv
// traffic_ctrl -- two-street traffic light controller with sensor extension,
// a pedestrian walk phase and an optional flashing-yellow mode.
//
// Optional feature macro: TRAFFIC_FLASH_EN
//   When defined, adds the flashMode input and the FLASH state (phase 7).
//   When undefined, the controller has no FLASH state and phase is never 7.
//
// Ports
//   clk         in   system clock, all state changes on the rising edge
//   rst         in   asynchronous active-high reset
//   Sensor      in   side-street vehicle present
//   walkButton  in   pedestrian request (level)
//   flashMode   in   (TRAFFIC_FLASH_EN only) force flashing main-yellow
//   walkLight   out  1 = walk indication lit
//   mainLight   out  main lamp: 00 red, 01 yellow, 10 green
//   sideLight   out  side lamp, same encoding
//   phase       out  current state encoding
module traffic_ctrl #(
    parameter int TICK_DIV     = 100000000,
    parameter int MAIN_GREEN_S = 6,
    parameter int SIDE_GREEN_S = 6,
    parameter int YELLOW_S     = 2,
    parameter int EXT_S        = 3,
    parameter int WALK_S       = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Sensor,
    input  logic       walkButton,
`ifdef TRAFFIC_FLASH_EN
    input  logic       flashMode,
`endif
    output logic       walkLight,
    output logic [1:0] mainLight,
    output logic [1:0] sideLight,
    output logic [2:0] phase
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAXD = max2(max2(max2(MAIN_GREEN_S, SIDE_GREEN_S),
                                    max2(YELLOW_S, EXT_S)), WALK_S);
    localparam int TW   = $clog2(MAXD + 1);
    localparam int PW   = $clog2(TICK_DIV);

    typedef enum logic [2:0] {
        MAIN_G   = 3'd0,
        MAIN_EXT = 3'd1,
        MAIN_Y   = 3'd2,
        WALK     = 3'd3,
        SIDE_G   = 3'd4,
        SIDE_EXT = 3'd5,
        SIDE_Y   = 3'd6
`ifdef TRAFFIC_FLASH_EN
        ,FLASH   = 3'd7
`endif
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            walkReq_q, walkReq_d;
`ifdef TRAFFIC_FLASH_EN
    logic            blink_q, blink_d;
`endif
    logic            walk_q;
    logic [1:0]      main_q, side_q;
    logic            tick, expire;
    logic [TW-1:0]   dur_m1;

    // Lamp pattern {walk, main, side} for each state; FLASH main lamp is
    // overlaid with the blink bit where the outputs are registered.
    function automatic logic [4:0] decode(input state_t s);
        case (s)
            MAIN_G, MAIN_EXT: return 5'b0_10_00;
            MAIN_Y:           return 5'b0_01_00;
            WALK:             return 5'b1_00_00;
            SIDE_G, SIDE_EXT: return 5'b0_00_10;
            SIDE_Y:           return 5'b0_00_01;
            default:          return 5'b0_00_00;
        endcase
    endfunction

    always_comb begin
        tick = (presc_q == PW'(TICK_DIV - 1));

        case (state_q)
            MAIN_G:           dur_m1 = TW'(MAIN_GREEN_S - 1);
            MAIN_EXT:         dur_m1 = TW'(EXT_S - 1);
            MAIN_Y:           dur_m1 = TW'(YELLOW_S - 1);
            WALK:             dur_m1 = TW'(WALK_S - 1);
            SIDE_G:           dur_m1 = TW'(SIDE_GREEN_S - 1);
            SIDE_EXT:         dur_m1 = TW'(EXT_S - 1);
            SIDE_Y:           dur_m1 = TW'(YELLOW_S - 1);
            default:          dur_m1 = '0;
        endcase
        expire = tick && (timer_q == dur_m1);

        state_d   = state_q;
        presc_d   = tick ? '0 : presc_q + PW'(1);
        timer_d   = tick ? timer_q + TW'(1) : timer_q;
        // A press on the MAIN_Y expiry cycle is seen through walkButton directly.
        walkReq_d = walkReq_q | (walkButton && (state_q != WALK));
`ifdef TRAFFIC_FLASH_EN
        blink_d   = blink_q;
`endif

        if (expire) begin
            case (state_q)
                MAIN_G:   state_d = Sensor ? MAIN_EXT : MAIN_Y;
                MAIN_EXT: state_d = MAIN_Y;
                MAIN_Y:   state_d = (walkReq_q || walkButton) ? WALK : SIDE_G;
                WALK:     state_d = SIDE_G;
                SIDE_G:   state_d = Sensor ? SIDE_EXT : SIDE_Y;
                SIDE_EXT: state_d = SIDE_Y;
                SIDE_Y:   state_d = MAIN_G;
                default:  state_d = MAIN_G;
            endcase
        end

`ifdef TRAFFIC_FLASH_EN
        // FLASH has no duration: the timer stays parked and blink follows ticks.
        if (state_q == FLASH) begin
            timer_d = '0;
            if (tick) blink_d = ~blink_q;
        end
        if (flashMode)
            state_d = FLASH;
        else if (state_q == FLASH)
            state_d = MAIN_G;
`endif

        // Every transition restarts timing so each phase lasts exactly N ticks.
        if (state_d != state_q) begin
            presc_d = '0;
            timer_d = '0;
`ifdef TRAFFIC_FLASH_EN
            blink_d = 1'b0;
`endif
            if (state_d == WALK) walkReq_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= MAIN_G;
            presc_q   <= '0;
            timer_q   <= '0;
            walkReq_q <= 1'b0;
`ifdef TRAFFIC_FLASH_EN
            blink_q   <= 1'b0;
`endif
            walk_q    <= 1'b0;
            main_q    <= 2'b10;
            side_q    <= 2'b00;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            timer_q   <= timer_d;
            walkReq_q <= walkReq_d;
`ifdef TRAFFIC_FLASH_EN
            blink_q   <= blink_d;
`endif
            {walk_q, main_q, side_q} <= decode(state_d);
`ifdef TRAFFIC_FLASH_EN
            if (state_d == FLASH) main_q <= {1'b0, blink_d};
`endif
        end
    end

    assign walkLight = walk_q;
    assign mainLight = main_q;
    assign sideLight = side_q;
    assign phase     = state_q;

endmodule
